// File: rtl/register_file_pkg.sv
// Shared encodings for the banked register file: pair operations, register
// and pair indices, and the clear-sweep states.
package register_file_pkg;

  typedef enum logic [1:0] {
    PAIR_NONE = 2'b00,
    PAIR_LOAD = 2'b01,
    PAIR_INC  = 2'b10,
    PAIR_DEC  = 2'b11
  } pair_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } clr_state_e;

  localparam int REG_A    = 0;
  localparam int REG_B    = 1;
  localparam int REG_C    = 2;
  localparam int REG_D    = 3;
  localparam int REG_E    = 4;
  localparam int REG_H    = 5;
  localparam int REG_L    = 6;
  localparam int REG_RSVD = 7;

  localparam int PAIR_BC = 0;
  localparam int PAIR_DE = 1;
  localparam int PAIR_HL = 2;

endpackage

// File: rtl/pair_incdec.sv
// Combinational register-pair increment/decrement; wrap flags the
// all-ones -> 0 (inc) or 0 -> all-ones (dec) transition.
module pair_incdec #(
  parameter int W = 16
) (
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic [W-1:0] result,
  output logic         wrap
);

  assign result = dec ? (value - W'(1)) : (value + W'(1));
  assign wrap   = dec ? (value == '0) : (value == '1);

endmodule

// File: rtl/register_file_banked.sv
// Dual-bank CPU register file: byte read/write ports, pair load/inc/dec,
// bank swap of the general registers, and a sequential clear sweep.
module register_file_banked
  import register_file_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = $clog2(NUM_REGS),
  parameter int PAIR_W   = SEL_W - 1,
  parameter int BYPASS   = 1,
  parameter int HL_PAIR  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [SEL_W-1:0]      wr_sel,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [SEL_W-1:0]      rd_sel_a,
  input  logic [SEL_W-1:0]      rd_sel_b,
  output logic [DATA_W-1:0]     rd_data_a,
  output logic [DATA_W-1:0]     rd_data_b,
  input  logic [1:0]            pair_op,
  input  logic [PAIR_W-1:0]     pair_sel,
  input  logic [2*DATA_W-1:0]   pair_data,
  input  logic [PAIR_W-1:0]     pair_rd_sel,
  output logic [2*DATA_W-1:0]   pair_rd_data,
  output logic [2*DATA_W-1:0]   hl_out,
  output logic                  pair_carry,
  input  logic                  bank_swap,
  output logic                  active_bank,
  input  logic                  clear_req,
  output logic                  busy
);

  localparam int NUM_PAIRS = (NUM_REGS - 2) / 2;
  // Slots 0..NUM_REGS-1 hold A, bank-0 generals and the reserved register;
  // slots NUM_REGS.. hold the bank-1 copies of the generals.
  localparam int NUM_SLOTS = 2 * NUM_REGS - 2;
  localparam int PW        = 2 * DATA_W;

  logic [DATA_W-1:0] store_reg [NUM_SLOTS];
  logic [DATA_W-1:0] view      [NUM_REGS];
  logic              view_upd  [NUM_REGS];
  logic [DATA_W-1:0] view_next [NUM_REGS];

  logic              active_bank_reg;
  logic              pair_carry_reg;
  clr_state_e        state_reg;
  logic [SEL_W-1:0]  sweep_idx_reg;

  logic              busy_w;
  logic              wr_do;
  logic              pair_valid;
  logic              pair_do;
  logic              pair_step;
  pair_op_e          op_w;
  logic [SEL_W-1:0]  hi_idx;
  logic [SEL_W-1:0]  lo_idx;
  logic [PW-1:0]     pair_cur;
  logic [PW-1:0]     pair_stepped;
  logic [PW-1:0]     pair_new;
  logic              pair_wrap;
  logic [SEL_W-1:0]  rd_hi_idx;
  logic [SEL_W-1:0]  rd_lo_idx;

  assign busy_w      = (state_reg == ST_SWEEP);
  assign busy        = busy_w;
  assign active_bank = active_bank_reg;
  assign pair_carry  = pair_carry_reg;

  // Active-bank view of every logical register index.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_view
      if (gi == 0 || gi == NUM_REGS - 1) begin : g_shared
        assign view[gi] = store_reg[gi];
      end else begin : g_banked
        assign view[gi] = active_bank_reg ? store_reg[gi + NUM_REGS - 1] : store_reg[gi];
      end
    end
  endgenerate

  assign op_w       = pair_op_e'(pair_op);
  assign wr_do      = wr_en && !busy_w;
  assign pair_valid = int'(pair_sel) < NUM_PAIRS;
  assign pair_do    = !busy_w && pair_valid && (op_w != PAIR_NONE);
  assign pair_step  = pair_do && (op_w == PAIR_INC || op_w == PAIR_DEC);
  assign hi_idx     = {pair_sel, 1'b1};
  assign lo_idx     = hi_idx + SEL_W'(1);
  assign pair_cur   = {view[hi_idx], view[lo_idx]};

  pair_incdec #(.W(PW)) u_incdec (
    .value  (pair_cur),
    .dec    (op_w == PAIR_DEC),
    .result (pair_stepped),
    .wrap   (pair_wrap)
  );

  assign pair_new = (op_w == PAIR_LOAD) ? pair_data : pair_stepped;

  // Per logical register: the pair op takes precedence over a byte write.
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_upd
      assign view_upd[gi]  = (pair_do && (hi_idx == SEL_W'(gi) || lo_idx == SEL_W'(gi)))
                           || (wr_do && wr_sel == SEL_W'(gi));
      assign view_next[gi] = (pair_do && hi_idx == SEL_W'(gi)) ? pair_new[PW-1:DATA_W] :
                             (pair_do && lo_idx == SEL_W'(gi)) ? pair_new[DATA_W-1:0] :
                             wr_data;
    end
  endgenerate

  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      localparam int LI     = (gi < NUM_REGS) ? gi : gi - (NUM_REGS - 1);
      localparam bit BK     = (gi >= NUM_REGS);
      localparam bit SHARED = (gi == 0) || (gi == NUM_REGS - 1);

      always_ff @(posedge clk) begin
        if (!reset) begin
          store_reg[gi] <= '0;
        end else if (busy_w) begin
          if (sweep_idx_reg == SEL_W'(LI)) store_reg[gi] <= '0;
        end else if (view_upd[LI] && (SHARED || active_bank_reg == BK)) begin
          store_reg[gi] <= view_next[LI];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      sweep_idx_reg   <= '0;
      active_bank_reg <= 1'b0;
      pair_carry_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (clear_req) begin
            state_reg     <= ST_SWEEP;
            sweep_idx_reg <= '0;
          end
        end
        ST_SWEEP: begin
          sweep_idx_reg <= sweep_idx_reg + SEL_W'(1);
          if (sweep_idx_reg == SEL_W'(NUM_REGS - 1)) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
      if (!busy_w && bank_swap) active_bank_reg <= ~active_bank_reg;
      if (pair_step) pair_carry_reg <= pair_wrap;
    end
  end

  always_comb begin
    rd_data_a = view[rd_sel_a];
    rd_data_b = view[rd_sel_b];
    if (BYPASS != 0 && wr_do && rd_sel_a == wr_sel) rd_data_a = wr_data;
    if (BYPASS != 0 && wr_do && rd_sel_b == wr_sel) rd_data_b = wr_data;
  end

  assign rd_hi_idx    = {pair_rd_sel, 1'b1};
  assign rd_lo_idx    = rd_hi_idx + SEL_W'(1);
  assign pair_rd_data = (int'(pair_rd_sel) < NUM_PAIRS) ? {view[rd_hi_idx], view[rd_lo_idx]} : '0;

  generate
    if (HL_PAIR < NUM_PAIRS) begin : g_hl
      assign hl_out = {view[2*HL_PAIR+1], view[2*HL_PAIR+2]};
    end else begin : g_hl_none
      assign hl_out = '0;
    end
  endgenerate

endmodule

// File: tb/tb_register_file_banked.sv
// Directed bench for register_file_banked with hand-computed expectations.
module tb_register_file_banked;
  import register_file_pkg::*;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [7:0]  wr_data;
  logic [2:0]  rd_sel_a;
  logic [2:0]  rd_sel_b;
  logic [7:0]  rd_data_a;
  logic [7:0]  rd_data_b;
  logic [1:0]  pair_op;
  logic [1:0]  pair_sel;
  logic [15:0] pair_data;
  logic [1:0]  pair_rd_sel;
  logic [15:0] pair_rd_data;
  logic [15:0] hl_out;
  logic        pair_carry;
  logic        bank_swap;
  logic        active_bank;
  logic        clear_req;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  register_file_banked dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_data      (wr_data),
    .rd_sel_a     (rd_sel_a),
    .rd_sel_b     (rd_sel_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .pair_op      (pair_op),
    .pair_sel     (pair_sel),
    .pair_data    (pair_data),
    .pair_rd_sel  (pair_rd_sel),
    .pair_rd_data (pair_rd_data),
    .hl_out       (hl_out),
    .pair_carry   (pair_carry),
    .bank_swap    (bank_swap),
    .active_bank  (active_bank),
    .clear_req    (clear_req),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctl();
    wr_en     = 1'b0;
    pair_op   = PAIR_NONE;
    bank_swap = 1'b0;
    clear_req = 1'b0;
  endtask

  initial begin
    logic [7:0] acc;
    int cnt;
    reset = 1'b0; wr_sel = '0; wr_data = '0; rd_sel_a = '0; rd_sel_b = '0;
    pair_sel = '0; pair_data = '0; pair_rd_sel = '0;
    idle_ctl();
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("rst_rd_a", 32'(rd_data_a), 32'h0);
    chk("rst_hl", 32'(hl_out), 32'h0);
    chk("rst_carry", 32'(pair_carry), 32'h0);
    chk("rst_bank", 32'(active_bank), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Byte writes B, C then pair read of BC
    wr_en = 1'b1; wr_sel = 3'd1; wr_data = 8'h12; rd_sel_b = 3'd1;
    #1 chk("bypass_b", 32'(rd_data_b), 32'h12);
    tick();
    wr_sel = 3'd2; wr_data = 8'h34;
    tick();
    wr_en = 1'b0; pair_rd_sel = 2'd0; rd_sel_a = 3'd1;
    #1;
    chk("bc_pair", 32'(pair_rd_data), 32'h1234);
    chk("b_read", 32'(rd_data_a), 32'h12);

    // HL wrap sequence
    pair_op = PAIR_LOAD; pair_sel = 2'd2; pair_data = 16'hFFFF;
    tick();
    chk("hl_load", 32'(hl_out), 32'hFFFF);
    pair_op = PAIR_INC; tick();
    chk("hl_inc_wrap", 32'(hl_out), 32'h0000);
    chk("carry_inc_wrap", 32'(pair_carry), 32'h1);
    pair_op = PAIR_DEC; tick();
    chk("hl_dec_wrap", 32'(hl_out), 32'hFFFF);
    chk("carry_dec_wrap", 32'(pair_carry), 32'h1);
    pair_op = PAIR_INC; tick();
    chk("hl_inc_wrap2", 32'(hl_out), 32'h0000);
    tick();
    chk("hl_inc", 32'(hl_out), 32'h0001);
    chk("carry_clr", 32'(pair_carry), 32'h0);

    // Invalid pair index: ignored, reads 0, carry unchanged
    pair_op = PAIR_DEC; pair_sel = 2'd3; tick();
    pair_op = PAIR_NONE; pair_rd_sel = 2'd3;
    #1;
    chk("bad_pair_rd", 32'(pair_rd_data), 32'h0);
    chk("bad_pair_carry", 32'(pair_carry), 32'h0);
    chk("bad_pair_hl", 32'(hl_out), 32'h0001);

    // Byte write inside pair vs pair load; byte write outside pair with inc
    wr_en = 1'b1; wr_sel = 3'd3; wr_data = 8'hAA;
    pair_op = PAIR_LOAD; pair_sel = 2'd1; pair_data = 16'h5566;
    tick();
    pair_rd_sel = 2'd1; #1;
    chk("de_pair_wins", 32'(pair_rd_data), 32'h5566);
    wr_sel = 3'd0; wr_data = 8'h77; pair_op = PAIR_INC;
    tick();
    idle_ctl(); rd_sel_a = 3'd0; #1;
    chk("a_with_inc", 32'(rd_data_a), 32'h77);
    chk("de_inc", 32'(pair_rd_data), 32'h5567);

    // Banking
    wr_en = 1'b1; wr_sel = 3'd0; wr_data = 8'h09; tick();
    wr_sel = 3'd1; wr_data = 8'h01; tick();
    wr_en = 1'b0; bank_swap = 1'b1; tick();
    chk("bank_is_1", 32'(active_bank), 32'h1);
    bank_swap = 1'b0; wr_en = 1'b1; wr_sel = 3'd1; wr_data = 8'h02; tick();
    wr_en = 1'b0; rd_sel_a = 3'd1; rd_sel_b = 3'd0; #1;
    chk("b_bank1", 32'(rd_data_a), 32'h02);
    chk("a_bank1", 32'(rd_data_b), 32'h09);
    bank_swap = 1'b1; tick();
    bank_swap = 1'b0; #1;
    chk("b_bank0", 32'(rd_data_a), 32'h01);
    chk("a_bank0", 32'(rd_data_b), 32'h09);
    // Write in the swap cycle lands in the old bank
    wr_en = 1'b1; wr_sel = 3'd2; wr_data = 8'h55; bank_swap = 1'b1; tick();
    idle_ctl(); rd_sel_a = 3'd2; #1;
    chk("c_bank1_untouched", 32'(rd_data_a), 32'h00);
    bank_swap = 1'b1; tick();
    bank_swap = 1'b0; #1;
    chk("c_bank0_written", 32'(rd_data_a), 32'h55);

    // Fill both banks then clear sweep
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) begin
        wr_en = 1'b1; wr_sel = 3'(i); wr_data = 8'(8'h80 + b * 16 + i); tick();
      end
      wr_en = 1'b0; bank_swap = 1'b1; tick();
      bank_swap = 1'b0;
    end
    pair_rd_sel = 2'd0; rd_sel_a = 3'd0; rd_sel_b = 3'd7; #1;
    chk("fill_bc", 32'(pair_rd_data), 32'h8182);
    chk("fill_a", 32'(rd_data_a), 32'h90);
    chk("fill_rsvd", 32'(rd_data_b), 32'h97);
    clear_req = 1'b1; tick();
    clear_req = 1'b0;
    wr_en = 1'b1; wr_sel = 3'd0; wr_data = 8'hFF; bank_swap = 1'b1;
    pair_op = PAIR_LOAD; pair_sel = 2'd0; pair_data = 16'h1111;
    #1;
    chk("sweep_busy", 32'(busy), 32'h1);
    chk("sweep_no_bypass", 32'(rd_data_a), 32'h90);
    cnt = 0;
    while (busy && cnt < 20) begin
      tick();
      cnt++;
    end
    idle_ctl();
    chk("sweep_cycles", 32'(cnt), 32'd8);
    chk("sweep_bank_held", 32'(active_bank), 32'h0);
    for (int b = 0; b < 2; b++) begin
      acc = '0;
      for (int i = 0; i < 8; i++) begin
        rd_sel_a = 3'(i); #1;
        acc = acc | rd_data_a;
      end
      chk(b == 0 ? "clear_bank0" : "clear_bank1", 32'(acc), 32'h0);
      bank_swap = 1'b1; tick();
      bank_swap = 1'b0;
    end
    chk("clear_busy_low", 32'(busy), 32'h0);

    // Reset in the middle of a sweep
    pair_op = PAIR_LOAD; pair_sel = 2'd1; pair_data = 16'hFFFF; tick();
    pair_op = PAIR_INC; tick();
    chk("pre_rst_carry", 32'(pair_carry), 32'h1);
    pair_op = PAIR_LOAD; pair_sel = 2'd2; pair_data = 16'hABCD; tick();
    pair_op = PAIR_NONE; #1;
    chk("carry_held_on_load", 32'(pair_carry), 32'h1);
    chk("pre_rst_hl", 32'(hl_out), 32'hABCD);
    clear_req = 1'b1; tick();
    clear_req = 1'b0; tick(); tick();
    reset = 1'b0; tick();
    reset = 1'b1; rd_sel_a = 3'd0; #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_hl", 32'(hl_out), 32'h0);
    chk("midrst_carry", 32'(pair_carry), 32'h0);
    chk("midrst_a", 32'(rd_data_a), 32'h0);

    // Bypass on E
    wr_en = 1'b1; wr_sel = 3'd4; wr_data = 8'h3C; rd_sel_b = 3'd4; rd_sel_a = 3'd3; #1;
    chk("bypass_e", 32'(rd_data_b), 32'h3C);
    chk("no_bypass_d", 32'(rd_data_a), 32'h0);
    tick();
    wr_en = 1'b0; #1;
    chk("e_stored", 32'(rd_data_b), 32'h3C);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/register_file_banked.md
# register_file_banked

Parametrised, dual-bank successor of the CPU register file. It provides:
- two combinational byte read ports with optional write bypass;
- a 16-bit-class register-pair port supporting load, increment and decrement (LXI/INX/DCX-style) with a wrap flag;
- an EXX-style bank swap of the general registers;
- a sequential clear sweep with a busy indication.

It sits between the decode/control unit and the ALU/address path, and drives `hl_out` to the memory address mux.

## Interface
Parameters:
- `DATA_W`, 8, register width in bits.
- `NUM_REGS`, 8, registers per bank; must be a power of two, ≥ 4.
- `SEL_W`, $clog2(NUM_REGS), register select width (derived).
- `PAIR_W`, SEL_W-1, pair select width (derived).
- `BYPASS`, 1, when 1 the read ports forward a same-cycle byte write.
- `HL_PAIR`, 2, pair index driven on `hl_out`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `wr_en` in 1: byte write enable.
- `wr_sel` in SEL_W: byte write register index.
- `wr_data` in DATA_W: byte write data.
- `rd_sel_a` / `rd_sel_b` in SEL_W: read indices.
- `rd_data_a` / `rd_data_b` out DATA_W: read data (combinational).
- `pair_op` in 2: pair operation; 00 none, 01 load, 10 inc, 11 dec.
- `pair_sel` in PAIR_W: pair index for `pair_op`.
- `pair_data` in 2*DATA_W: pair load data, high byte in the upper bits.
- `pair_rd_sel` in PAIR_W: pair read index.
- `pair_rd_data` out 2*DATA_W: pair read data (combinational).
- `hl_out` out 2*DATA_W: contents of pair `HL_PAIR`.
- `pair_carry` out 1: registered wrap flag of the last inc/dec.
- `bank_swap` in 1: toggle the active bank.
- `active_bank` out 1: current bank.
- `clear_req` in 1: start a clear sweep.
- `busy` out 1: clear sweep in progress.

## Operation
- Index 0 is A. Index NUM_REGS-1 is reserved. Indices 1..NUM_REGS-2 are general registers.
- Pair p maps to high byte register 2p+1 and low byte register 2p+2, for p < (NUM_REGS-2)/2. With the default parameters this gives BC=0, DE=1, HL=2.
- Pair index (NUM_REGS-2)/2 and above is invalid:
  - reads return 0;
  - `pair_op` is ignored;
  - `pair_carry` is unchanged.
- Banking:
  - A and the reserved register are single copies.
  - General registers exist in bank 0 and bank 1.
  - All accesses target `active_bank`.
- Byte write: when `wr_en` is set, the selected register loads `wr_data` at the edge.
- Pair load: the pair loads `pair_data`.
- Pair inc/dec:
  - The pair becomes the pair value ±1, modulo 2^(2*DATA_W).
  - `pair_carry` is set to 1 when inc wraps from all-ones to 0, or dec wraps from 0 to all-ones; otherwise it is set to 0.
  - `pair_carry` holds its value on non-inc/dec cycles.
- Simultaneous byte write and pair op:
  - If the written byte lies inside the pair, the pair op wins for that byte.
  - Otherwise both take effect.
- `bank_swap`: `active_bank` toggles at the edge. Writes and pair ops in the same cycle target the bank that was active before the toggle.
- Bypass (`BYPASS`=1): if `wr_en` is set, `busy`=0, and `rd_sel_x` equals `wr_sel`, then `rd_data_x` = `wr_data`. No bypass applies to pair ops or `pair_rd_data`.
- Clear FSM:
  - States are IDLE and SWEEP.
  - IDLE→SWEEP occurs on `clear_req`. The index counter is set to 0.
  - In SWEEP, each edge clears register idx in both banks, then increments idx.
  - SWEEP→IDLE after clearing index NUM_REGS-1.
  - While `busy`, the following are ignored: `wr_en`, `pair_op`, `bank_swap`, `clear_req`.
  - Reads during SWEEP return the partially cleared contents.

## Timing
- On reset (`reset`=0 at an edge):
  - all registers in both banks become 0;
  - `active_bank`=0, `pair_carry`=0, `busy`=0, FSM=IDLE;
  - every read output, `pair_rd_data` and `hl_out` read 0 after the edge.
- Reset mid-sweep aborts to IDLE with everything zero.
- Reset has priority over all other inputs.
- Write latency is 1 edge: the new value is visible on all read ports in the cycle after the edge. The only exception is the bypass, which is visible in the same cycle.
- Clear sweep timing:
  - `clear_req` sampled at edge k in IDLE.
  - `busy`=1 from edge k through edge k+NUM_REGS.
  - Register i is cleared at edge k+1+i.
  - `busy`=0 after edge k+NUM_REGS; a new request is accepted at that edge or later.
- `pair_carry` and `active_bank` update at the same edge as the operation that changes them.

## Structure
- A shared package `register_file_pkg` holds:
  - `pair_op` encodings (PAIR_NONE, PAIR_LOAD, PAIR_INC, PAIR_DEC);
  - register index constants (REG_A, REG_B … REG_L, REG_RSVD);
  - pair constants (PAIR_BC, PAIR_DE, PAIR_HL);
  - the clear FSM state enum (ST_IDLE, ST_SWEEP).
- One sub-module, `pair_incdec`: combinational 2*DATA_W increment/decrement with a wrap output. It is instantiated once.
- Storage, banking, write arbitration and the FSM stay in the top module.

## Test plan
- Reset, then byte write B=8'h12 and C=8'h34 → `pair_rd_data`(BC)=16'h1234; `rd_data_a`(B)=8'h12 on the next cycle.
- Load HL=16'hFFFF, then inc → `hl_out`=16'h0000, `pair_carry`=1. Then dec → 16'hFFFF, `pair_carry`=1. Then inc again → 16'h0000; a further inc → 16'h0001, `pair_carry`=0.
- Same cycle: byte write D=8'hAA with pair load DE=16'h5566 → DE=16'h5566. Same cycle: byte write A=8'h77 with DE inc → A=8'h77 and DE=16'h5567.
- Write B=8'h01 in bank 0, then swap and write B=8'h02, then swap again → B reads 8'h01. Write A=8'h9 before the swaps → A reads 8'h9 in both banks.
- Fill every register in both banks, assert `clear_req` → `busy` stays high for 8 cycles, and `wr_en` during the sweep is ignored. Afterwards all reads are 0 in both banks and `busy`=0.
- Assert `reset`=0 at sweep cycle 3 → all outputs 0, `busy`=0 the next cycle. With BYPASS=1, `wr_en` writing E=8'h3C with `rd_sel_b`=E → `rd_data_b`=8'h3C in the same cycle.
